// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header size and state types for the UART ALU packet processor.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO   = 8'hEC;
  localparam logic [7:0] OP_ADD32  = 8'hAD;
  localparam int         HDR_BYTES = 4;

  typedef enum logic [2:0] {
    P_IDLE,
    P_RES,
    P_LEN_LO,
    P_LEN_HI,
    P_PAYLOAD,
    P_RESULT
  } parse_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  // Payload byte count from the total packet length; short lengths clamp to zero.
  function automatic logic [15:0] payload_len(input logic [15:0] total);
    return (total > 16'(HDR_BYTES)) ? total - 16'(HDR_BYTES) : 16'd0;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid pulse per good byte.
module uart_byte_rx
  import uart_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  // state   | meaning
  // B_IDLE  | waiting for a falling edge on the synchronized line
  // B_START | half-bit wait, start bit re-checked at its midpoint
  // B_DATA  | eight data bits sampled at mid-bit, LSB first
  // B_STOP  | stop bit sampled; low stop bit drops the byte

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

  // sync[1] is the synchronized line, sync[2] its previous value for edge detect
  logic [2:0]    sync;
  bit_state_t    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          valid_nxt;
  logic          rx_s, tc;

  assign rx_s    = sync[1];
  assign tc      = (timer == '0);
  assign rx_data = shift;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync     <= 3'b111;
      state    <= B_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync     <= {sync[1:0], rx_i};
      state    <= state_nxt;
      timer    <= timer_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      rx_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = tc ? timer : timer - TW'(1);
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    valid_nxt   = 1'b0;
    case (state)
      B_IDLE: begin
        timer_nxt = timer;
        if (sync[2] && !rx_s) begin
          state_nxt = B_START;
          timer_nxt = HALF_BIT;
        end
      end
      B_START: if (tc) begin
        if (rx_s) begin
          state_nxt = B_IDLE;
        end else begin
          state_nxt   = B_DATA;
          timer_nxt   = FULL_BIT;
          bit_cnt_nxt = '0;
        end
      end
      B_DATA: if (tc) begin
        shift_nxt   = {rx_s, shift[7:1]};
        timer_nxt   = FULL_BIT;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = B_STOP;
      end
      B_STOP: if (tc) begin
        state_nxt = B_IDLE;
        valid_nxt = rx_s;
      end
      default: state_nxt = B_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART 8N1 transmitter; pulls the next byte at the end of a stop bit so bursts have no idle gap.
module uart_byte_tx
  import uart_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tx_avail,
  input  logic [7:0] tx_byte,
  output logic       tx_pop,
  output logic       tx_line,
  output logic       active
);

  // state   | meaning
  // B_IDLE  | line high, waiting for a byte to become available
  // B_START | start bit (low)
  // B_DATA  | eight data bits, LSB first
  // B_STOP  | stop bit (high); next byte is popped at its end if available

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);

  bit_state_t    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          line_nxt, tc;

  assign tc     = (timer == '0);
  assign active = (state != B_IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= B_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_line <= 1'b1;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      tx_line <= line_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = tc ? timer : timer - TW'(1);
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    tx_pop      = 1'b0;
    case (state)
      B_IDLE: begin
        timer_nxt = timer;
        if (tx_avail) begin
          tx_pop    = 1'b1;
          shift_nxt = tx_byte;
          state_nxt = B_START;
          timer_nxt = FULL_BIT;
        end
      end
      B_START: if (tc) begin
        state_nxt   = B_DATA;
        timer_nxt   = FULL_BIT;
        bit_cnt_nxt = '0;
      end
      B_DATA: if (tc) begin
        timer_nxt = FULL_BIT;
        if (bit_cnt == 3'd7) begin
          state_nxt = B_STOP;
        end else begin
          shift_nxt   = {1'b0, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      B_STOP: if (tc) begin
        if (tx_avail) begin
          tx_pop    = 1'b1;
          shift_nxt = tx_byte;
          state_nxt = B_START;
          timer_nxt = FULL_BIT;
        end else begin
          state_nxt = B_IDLE;
        end
      end
      default: state_nxt = B_IDLE;
    endcase

    case (state_nxt)
      B_START: line_nxt = 1'b0;
      B_DATA:  line_nxt = shift_nxt[0];
      default: line_nxt = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_alu_core.sv
// UART packet processor: parses framed commands, executes echo / 32-bit add, queues response bytes for TX.
module uart_alu_core
  import uart_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 104,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic tx_o,
  output logic busy_o
);

  // state     | meaning
  // P_IDLE    | waiting for opcode byte
  // P_RES     | reserved header byte, ignored
  // P_LEN_LO  | length low byte
  // P_LEN_HI  | length high byte; payload count computed, add state cleared
  // P_PAYLOAD | consuming payload bytes (echo pushes, add accumulates)
  // P_RESULT  | pushing the 4-byte add result, MSB first

  localparam int AW = $clog2(TX_FIFO_DEPTH);

  logic       rx_valid;
  logic [7:0] rx_data;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .rx_i     (rx_i),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  logic [7:0] fifo_mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, push_ok, pop;
  logic [7:0]  push_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = push && !fifo_full;

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic tx_active;

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .tx_avail (!fifo_empty),
    .tx_byte  (fifo_mem[rd_ptr[AW-1:0]]),
    .tx_pop   (pop),
    .tx_line  (tx_o),
    .active   (tx_active)
  );

  parse_state_t state, state_nxt;
  logic [7:0]   opcode, len_lo;
  logic [15:0]  remaining;
  logic [23:0]  word_buf;
  logic [1:0]   byte_cnt, res_cnt;
  logic [31:0]  sum;
  logic         is_add;

  assign is_add = (opcode == OP_ADD32);
  assign busy_o = (state != P_IDLE) || !fifo_empty || tx_active;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = rx_data;
    case (state)
      P_IDLE:   if (rx_valid) state_nxt = P_RES;
      P_RES:    if (rx_valid) state_nxt = P_LEN_LO;
      P_LEN_LO: if (rx_valid) state_nxt = P_LEN_HI;
      P_LEN_HI: if (rx_valid) begin
        if (payload_len({rx_data, len_lo}) == 16'd0) state_nxt = is_add ? P_RESULT : P_IDLE;
        else                                          state_nxt = P_PAYLOAD;
      end
      P_PAYLOAD: if (rx_valid) begin
        push = (opcode == OP_ECHO);
        if (remaining == 16'd1) state_nxt = is_add ? P_RESULT : P_IDLE;
      end
      P_RESULT: begin
        push      = 1'b1;
        push_data = sum[31:24];
        if (res_cnt == 2'd3) state_nxt = P_IDLE;
      end
      default: state_nxt = P_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= P_IDLE;
      opcode    <= '0;
      len_lo    <= '0;
      remaining <= '0;
      word_buf  <= '0;
      byte_cnt  <= '0;
      res_cnt   <= '0;
      sum       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        P_IDLE:   if (rx_valid) opcode <= rx_data;
        P_LEN_LO: if (rx_valid) len_lo <= rx_data;
        P_LEN_HI: if (rx_valid) begin
          remaining <= payload_len({rx_data, len_lo});
          word_buf  <= '0;
          byte_cnt  <= '0;
          res_cnt   <= '0;
          sum       <= '0;
        end
        P_PAYLOAD: if (rx_valid) begin
          remaining <= remaining - 16'd1;
          if (is_add) begin
            // Only complete 4-byte words reach the sum; a trailing partial word is never added.
            word_buf <= {word_buf[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) sum <= sum + {word_buf, rx_data};
          end
        end
        P_RESULT: begin
          sum     <= {sum[23:0], 8'h00};
          res_cnt <= res_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_core.sv
// Scoreboard bench for uart_alu_core: serial stimulus, expected bytes queued at issue, TX line monitor compares.
module tb_uart_alu_core;

  localparam int CPB      = 8;
  localparam int BYTE_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic rx_i = 1'b1;
  logic tx_o, busy_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl[$];
  int starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_alu_core #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(16)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .rx_i    (rx_i),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    rx_i = !bad_stop;
    tick(CPB);
    if (bad_stop) begin
      rx_i = 1'b1;
      tick(2 * CPB);
    end
  endtask

  // Reference behaviour: echo returns the payload, add returns the big-endian sum of whole words.
  task automatic model(input logic [7:0] op);
    logic [31:0] s;
    if (op == 8'hEC) begin
      foreach (pl[i]) exp_q.push_back(pl[i]);
    end else if (op == 8'hAD) begin
      s = 32'd0;
      for (int w = 0; w + 3 < pl.size(); w += 4)
        s = s + {pl[w], pl[w+1], pl[w+2], pl[w+3]};
      exp_q.push_back(s[31:24]);
      exp_q.push_back(s[23:16]);
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
    end
  endtask

  task automatic send_pkt(input logic [7:0] op, input int len);
    model(op);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (pl[i]) send_byte(pl[i]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    check({name, " busy_o drains"}, int'(busy_o), 0);
    tick(4);
    check({name, " bytes outstanding"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    logic stop;
    bit ab;
    int st;
    forever begin
      @(negedge clk);
      if (!reset_i && tx_o === 1'b0) begin
        ab = 1'b0;
        st = cyc;
        for (int k = 0; k < CPB / 2; k++) begin
          @(negedge clk);
          if (reset_i) ab = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (reset_i) ab = 1'b1;
          end
          b[i] = tx_o;
        end
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          if (reset_i) ab = 1'b1;
        end
        stop = tx_o;
        if (!ab) begin
          starts.push_back(st);
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL tx_byte: got %02h with no byte expected", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e || stop !== 1'b1) begin
              mismatched++;
              $display("FAIL tx_byte: got %02h stop %0b expected %02h stop 1", b, stop, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached, compared %0d", compared);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    tick(3);
    check("reset tx_o", int'(tx_o), 1);
    check("reset busy_o", int'(busy_o), 0);
    reset_i = 1'b0;
    tick(2 * CPB);

    pl = '{8'h48, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(8'hEC, 12);
    wait_idle("echo", 40 * BYTE_CYC);

    pl = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    starts.delete();
    send_pkt(8'hAD, 12);
    wait_idle("add", 40 * BYTE_CYC);
    check("add result back-to-back", (starts.size() == 4) ? starts[3] - starts[0] : -1, 3 * BYTE_CYC);

    pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h05};
    send_pkt(8'hAD, 16);
    wait_idle("add overflow", 40 * BYTE_CYC);

    pl.delete();
    send_pkt(8'hAD, 4);
    wait_idle("add zero operands", 40 * BYTE_CYC);

    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(8'hAD, 9);
    wait_idle("add partial word", 40 * BYTE_CYC);

    pl.delete();
    send_pkt(8'hAD, 2);
    wait_idle("add short length", 40 * BYTE_CYC);

    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(8'h42, 8);
    pl = '{8'h5A};
    send_pkt(8'hEC, 5);
    wait_idle("unknown then echo", 40 * BYTE_CYC);

    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h1A, 8'h98, 8'h31, 8'hAB};
    send_pkt(8'hEC, 12);
    send_pkt(8'hEC, 12);
    wait_idle("back-to-back echo", 2 * BYTE_CYC);

    exp_q.push_back(8'h5A);
    send_byte(8'hEC);
    send_byte(8'h00);
    send_byte(8'h77, 1'b1);
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h5A);
    wait_idle("framing error", 40 * BYTE_CYC);

    exp_q.push_back(8'h48);
    send_byte(8'hEC);
    send_byte(8'h00);
    send_byte(8'h0C);
    send_byte(8'h00);
    send_byte(8'h48);
    send_byte(8'h69);
    n = 0;
    while (tx_o !== 1'b0 && n < BYTE_CYC) begin
      tick(1);
      n++;
    end
    check("pre-reset tx_o low", int'(tx_o), 0);
    check("pre-reset busy_o", int'(busy_o), 1);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    exp_q.delete();
    check("post-reset tx_o", int'(tx_o), 1);
    check("post-reset busy_o", int'(busy_o), 0);
    tick(2 * BYTE_CYC);
    pl = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    send_pkt(8'hAD, 12);
    wait_idle("after reset add", 40 * BYTE_CYC);

    for (int t = 0; t < 8; t++) begin
      int sel;
      int cnt;
      int len;
      logic [7:0] op;
      sel = $urandom_range(0, 2);
      op = (sel == 0) ? 8'hEC : (sel == 1) ? 8'hAD : 8'($urandom_range(0, 255));
      if (sel == 2 && (op == 8'hEC || op == 8'hAD)) op = 8'h13;
      if ($urandom_range(0, 4) == 0) begin
        cnt = 0;
        len = $urandom_range(0, 4);
      end else begin
        cnt = $urandom_range(1, 10);
        len = cnt + 4;
      end
      pl.delete();
      repeat (cnt) pl.push_back(8'($urandom_range(0, 255)));
      send_pkt(op, len);
      wait_idle("random packet", 40 * BYTE_CYC);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_alu_core.md
Name: uart_alu_core

Overview:
- UART packet processor for the iCE40 UART-ALU.
- Receives framed command packets on a serial RX line: opcode, reserved, length LSB, length MSB, then payload.
- Executes echo or 32-bit add and transmits the response bytes on a serial TX line.
- Sits between the board UART pins and nothing else; it is the top-level functional block.

Parameters:
- CLKS_PER_BIT, default 104, clock cycles per UART bit (baud = f_clk / CLKS_PER_BIT); must be >= 8.
- TX_FIFO_DEPTH, default 16, byte entries buffering TX responses; power of two.

Ports:
- clk_i, input, 1, system clock.
- reset_i, input, 1, synchronous active-high reset.
- rx_i, input, 1, UART receive line, idle high, 8N1, LSB first.
- tx_o, output, 1, UART transmit line, idle high, 8N1, LSB first.
- busy_o, output, 1, high while a packet is being parsed or TX data is pending.

Behaviour:
- Reset: tx_o=1, busy_o=0, parser in IDLE, TX FIFO empty, RX/TX bit engines idle.
- Any reset_i assertion, including mid-byte or mid-packet, aborts all activity and returns to the reset state on the next edge.
- RX bit engine:
  - rx_i passes through a 2-flop synchronizer.
  - A falling edge while idle starts a frame; the start bit is re-checked at CLKS_PER_BIT/2 and the frame is aborted if rx_i is high.
  - 8 data bits are sampled at mid-bit, then the stop bit.
  - A low stop bit causes the byte to be dropped (framing error, no parser effect).
  - A valid byte gives a 1-cycle rx_valid pulse with rx_data.
- Parser FSM:
  - States: IDLE, RES, LEN_LO, LEN_HI, PAYLOAD, RESULT.
  - IDLE: latch opcode, go to RES.
  - RES: byte ignored, go to LEN_LO.
  - LEN_LO, LEN_HI: form 16-bit length = total packet bytes including the 4 header bytes; remaining = length - 4, saturating at 0.
  - After LEN_HI: if remaining==0, go to RESULT (add) or IDLE; otherwise go to PAYLOAD.
  - PAYLOAD: consume exactly `remaining` bytes, decrementing per byte.
- Opcode 0xEC (echo): each payload byte is pushed to the TX FIFO in the same cycle it is received, in order. No header is echoed.
- Opcode 0xAD (add):
  - Payload is taken as consecutive 32-bit big-endian operands (first byte = MSB).
  - Accumulator is cleared at LEN_HI and shifts in bytes.
  - At each 4th byte the word is added modulo 2^32; trailing partial words are ignored.
  - In RESULT, push 4 result bytes MSB first (one per cycle), then return to IDLE.
  - Zero operands yields result 0x00000000.
- Other opcodes: payload is consumed and discarded, no response.
- TX FIFO:
  - A push when full is dropped.
  - Push and pop in the same cycle are both allowed.
- TX bit engine: when idle and FIFO non-empty, pop and send start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles long. Back-to-back bytes are sent with no idle gap.
- Header bytes of a new packet may arrive while TX is still draining the previous response; RX and TX are fully independent.
- busy_o = (parser != IDLE) or FIFO non-empty or TX engine active.

Decomposition:
- Shared package uart_alu_pkg:
  - OP_ECHO=8'hEC, OP_ADD32=8'hAD, HDR_BYTES=4.
  - Parser state enum typedef.
- Sub-modules:
  - uart_byte_rx (synchronizer + RX bit engine).
  - uart_byte_tx (TX bit engine).
  - Both parameterized by CLKS_PER_BIT; the FIFO and parser stay inline.

Test Plan:
- Echo: EC 00 0C 00 48 69 01 02 03 04 05 06 -> tx_o emits 48 69 01 02 03 04 05 06, in order, back-to-back.
- Add: AD 00 0C 00 00 00 00 01 00 00 00 02 -> tx_o emits 00 00 00 03.
- Add overflow/three operands: AD 00 10 00 FF FF FF FF 00 00 00 02 00 00 00 05 -> 00 00 00 06.
- Unknown opcode: AD-less packet 42 00 08 00 DE AD BE EF -> no TX activity; a following echo EC 00 05 00 5A -> 5A only.
- Back-to-back: two echo packets EC 00 0C 00 DE AD BE EF 1A 98 31 AB sent without a gap -> 16 bytes out, correct order, busy_o low ~1 byte-time after the last stop bit.
- Robustness:
  - A framing-error byte is dropped; the parser does not advance.
  - reset_i pulsed mid-payload -> tx_o=1 and busy_o=0 next cycle; the next full packet is processed correctly.
